// File: rtl/sent_rx_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sent_rx_frame_decoder
// Purpose  : SENT receive-side frame decoder. It measures the time between
//            falling edges of the SENT line in oversampled ticks and locks on
//            the sync pulse. It then decodes the status nibble, DATA_NIBBLES
//            data nibbles and the CRC nibble, and reports each complete frame
//            with a one-cycle strobe.
// Option   : SENT_RX_CRC_CHECK_EN -- when defined, the received CRC is checked
//            against the computed CRC. A mismatch raises crc_err_o instead of
//            frame_valid_o. When undefined, no CRC logic is built and
//            crc_err_o is tied to 0.
// Ports    : clk_rx        receiver clock
//            reset_rx      synchronous active-high reset
//            ticks_i       oversample strobe, OVS strobes per nominal tick
//            sent_rx_i     asynchronous SENT line
//            frame_valid_o 1-clk strobe: frame complete (CRC good if checked)
//            status_o      status nibble of last frame
//            data_o        data nibbles, first received in MS nibble
//            crc_o         received CRC nibble
//            crc_err_o     1-clk strobe: CRC mismatch
//            pulse_err_o   1-clk strobe: bad nibble or timeout inside a frame
//            busy_o        high while decoding STATUS/DATA/CRC
// Revision : 1.0 initial release
// ============================================================================
module sent_rx_frame_decoder #(
   parameter int DATA_NIBBLES = 6,
   parameter int OVS_LOG2     = 3,
   parameter int SYNC_TOL     = 45,
   parameter int CNT_W        = 13
) (
   input  logic                      clk_rx,
   input  logic                      reset_rx,
   input  logic                      ticks_i,
   input  logic                      sent_rx_i,
   output logic                      frame_valid_o,
   output logic [3:0]                status_o,
   output logic [4*DATA_NIBBLES-1:0] data_o,
   output logic [3:0]                crc_o,
   output logic                      crc_err_o,
   output logic                      pulse_err_o,
   output logic                      busy_o
);

   localparam int              c_OVS      = 1 << OVS_LOG2;
   localparam logic [CNT_W:0]  c_SYNC_MIN = (CNT_W+1)'(56*c_OVS - SYNC_TOL);
   localparam logic [CNT_W:0]  c_SYNC_MAX = (CNT_W+1)'(56*c_OVS + SYNC_TOL);
   localparam logic [CNT_W:0]  c_HALF     = (CNT_W+1)'(c_OVS/2);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
   localparam logic [2:0]      c_LAST_IDX = 3'(DATA_NIBBLES-1);
   localparam logic [3:0]      c_CRC_SEED = 4'b0101;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_SYNC = 3'd1,
      S_STATUS    = 3'd2,
      S_DATA      = 3'd3,
      S_CRC       = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_sync1, r_sync2, r_hist;
   logic [CNT_W-1:0]    r_cnt;
   logic [2:0]          r_idx;
   logic [3:0]          r_status;
   logic [3:0]          r_crc_rx;
   logic                r_pend;
   logic [3:0]          r_nib [DATA_NIBBLES];

   logic                w_fall;
   logic                w_sat;
   logic [CNT_W:0]      w_meas;
   logic [CNT_W:0]      w_t;
   logic                w_nib_ok;
   logic                w_sync_ok;
   logic [3:0]          w_nib;
   logic [4*DATA_NIBBLES-1:0] w_data;

`ifdef SENT_RX_CRC_CHECK_EN
   logic [3:0]          r_crc;

   // One nibble through the x^4+x^3+x^2+1 CRC, MSB first.
   function automatic logic [3:0] f_crc_nib(input logic [3:0] crc, input logic [3:0] d);
      logic [3:0] c;
      logic       fb;
      c = crc;
      for (int b = 3; b >= 0; b--) begin
         fb = c[3] ^ d[b];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0);
      end
      return c;
   endfunction
`endif

   assign w_fall    = r_hist & ~r_sync2;
   assign w_sat     = (r_cnt == c_CNT_MAX);
   // A tick in the same cycle as the fall still belongs to the interval.
   assign w_meas    = {1'b0, r_cnt} + {{CNT_W{1'b0}}, ticks_i};
   assign w_t       = (w_meas + c_HALF) >> OVS_LOG2;
   assign w_nib_ok  = (w_t >= (CNT_W+1)'(12)) && (w_t <= (CNT_W+1)'(27));
   // t is 12..27 whenever this is used, so the low 4 bits minus 12 give t-12.
   assign w_nib     = w_t[3:0] - 4'd12;
   assign w_sync_ok = (w_meas >= c_SYNC_MIN) && (w_meas <= c_SYNC_MAX);
   assign busy_o    = (r_state == S_STATUS) || (r_state == S_DATA) || (r_state == S_CRC);

   always_comb begin
      w_data = '0;
      for (int i = 0; i < DATA_NIBBLES; i++) begin
         w_data[4*(DATA_NIBBLES-1-i) +: 4] = r_nib[i];
      end
   end

   always_ff @(posedge clk_rx) begin
      if (reset_rx) begin
         r_state       <= S_IDLE;
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_hist        <= 1'b1;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_status      <= '0;
         r_crc_rx      <= '0;
         r_pend        <= 1'b0;
         frame_valid_o <= 1'b0;
         crc_err_o     <= 1'b0;
         pulse_err_o   <= 1'b0;
         status_o      <= '0;
         data_o        <= '0;
         crc_o         <= '0;
         for (int i = 0; i < DATA_NIBBLES; i++) begin
            r_nib[i] <= '0;
         end
`ifdef SENT_RX_CRC_CHECK_EN
         r_crc         <= '0;
`endif
      end else begin
         r_sync1       <= sent_rx_i;
         r_sync2       <= r_sync1;
         r_hist        <= r_sync2;
         frame_valid_o <= 1'b0;
         crc_err_o     <= 1'b0;
         pulse_err_o   <= 1'b0;
         r_pend        <= 1'b0;

         if ((r_state == S_IDLE) || w_fall) begin
            r_cnt <= '0;
         end else if (ticks_i && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
         end

         // Results are published one clock after the fall ending the CRC.
         if (r_pend) begin
            status_o <= r_status;
            data_o   <= w_data;
            crc_o    <= r_crc_rx;
`ifdef SENT_RX_CRC_CHECK_EN
            if (r_crc_rx == r_crc) begin
               frame_valid_o <= 1'b1;
            end else begin
               crc_err_o <= 1'b1;
            end
`else
            frame_valid_o <= 1'b1;
`endif
         end

         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state <= S_WAIT_SYNC;
               end
            end
            S_WAIT_SYNC: begin
               if (w_fall && w_sync_ok) begin
                  r_state <= S_STATUS;
               end
            end
            S_STATUS: begin
               if (w_fall) begin
                  if (w_nib_ok) begin
                     r_status <= w_nib;
                     r_idx    <= '0;
`ifdef SENT_RX_CRC_CHECK_EN
                     r_crc    <= c_CRC_SEED;
`endif
                     r_state  <= S_DATA;
                  end else begin
                     pulse_err_o <= 1'b1;
                     r_state     <= S_WAIT_SYNC;
                  end
               end else if (w_sat) begin
                  pulse_err_o <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            S_DATA: begin
               if (w_fall) begin
                  if (w_nib_ok) begin
                     r_nib[r_idx] <= w_nib;
                     r_idx        <= r_idx + 3'd1;
`ifdef SENT_RX_CRC_CHECK_EN
                     // The last data nibble is followed by one augmenting zero nibble.
                     if (r_idx == c_LAST_IDX) begin
                        r_crc <= f_crc_nib(f_crc_nib(r_crc, w_nib), 4'h0);
                     end else begin
                        r_crc <= f_crc_nib(r_crc, w_nib);
                     end
`endif
                     if (r_idx == c_LAST_IDX) begin
                        r_state <= S_CRC;
                     end
                  end else begin
                     pulse_err_o <= 1'b1;
                     r_state     <= S_WAIT_SYNC;
                  end
               end else if (w_sat) begin
                  pulse_err_o <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            S_CRC: begin
               if (w_fall) begin
                  r_state <= S_WAIT_SYNC;
                  if (w_nib_ok) begin
                     r_crc_rx <= w_nib;
                     r_pend   <= 1'b1;
                  end else begin
                     pulse_err_o <= 1'b1;
                  end
               end else if (w_sat) begin
                  pulse_err_o <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
